// File: rtl/hyst_pingpong_ctrl_if.sv
// hyst_pingpong_ctrl_if
//   Bundles every non-clock/reset signal of hyst_pingpong_ctrl.
//   Groups:
//     hyst_*   : hysteresis producer (write strobe/address/data, end-of-frame pulse)
//     hough_*  : Hough consumer (start pulse, read strobe/address/data/valid, done pulse)
//     bankN_*  : two external 1-cycle-latency BRAMs (write port, read address, read data)
//     status   : wr_ready, frame_count, overflow_err, protocol_err
//   Modports:
//     slave  : the controller side (hyst_pingpong_ctrl)
//     master : the environment side (producer, consumer and BRAMs)
interface hyst_pingpong_ctrl_if #(
    parameter int unsigned REDUCED_IMAGE_SIZE = 233910
);
    localparam int unsigned ADDR_W = $clog2(REDUCED_IMAGE_SIZE);

    logic              hyst_wr_en;
    logic [ADDR_W-1:0] hyst_wr_addr;
    logic [7:0]        hyst_wr_data;
    logic              hyst_done;
    logic              wr_ready;

    logic              hough_start;
    logic              hough_rd_en;
    logic [ADDR_W-1:0] hough_rd_addr;
    logic [7:0]        hough_rd_data;
    logic              hough_rd_valid;
    logic              hough_done;

    logic              bank0_wr_en;
    logic [ADDR_W-1:0] bank0_wr_addr;
    logic [7:0]        bank0_wr_data;
    logic [ADDR_W-1:0] bank0_rd_addr;
    logic [7:0]        bank0_rd_data;

    logic              bank1_wr_en;
    logic [ADDR_W-1:0] bank1_wr_addr;
    logic [7:0]        bank1_wr_data;
    logic [ADDR_W-1:0] bank1_rd_addr;
    logic [7:0]        bank1_rd_data;

    logic [15:0]       frame_count;
    logic              overflow_err;
    logic              protocol_err;

    modport slave (
        input  hyst_wr_en, hyst_wr_addr, hyst_wr_data, hyst_done,
        input  hough_rd_en, hough_rd_addr, hough_done,
        input  bank0_rd_data, bank1_rd_data,
        output wr_ready, hough_start, hough_rd_data, hough_rd_valid,
        output bank0_wr_en, bank0_wr_addr, bank0_wr_data, bank0_rd_addr,
        output bank1_wr_en, bank1_wr_addr, bank1_wr_data, bank1_rd_addr,
        output frame_count, overflow_err, protocol_err
    );

    modport master (
        output hyst_wr_en, hyst_wr_addr, hyst_wr_data, hyst_done,
        output hough_rd_en, hough_rd_addr, hough_done,
        output bank0_rd_data, bank1_rd_data,
        input  wr_ready, hough_start, hough_rd_data, hough_rd_valid,
        input  bank0_wr_en, bank0_wr_addr, bank0_wr_data, bank0_rd_addr,
        input  bank1_wr_en, bank1_wr_addr, bank1_wr_data, bank1_rd_addr,
        input  frame_count, overflow_err, protocol_err
    );
endinterface

// File: rtl/hyst_pingpong_ctrl.sv
// hyst_pingpong_ctrl
//   Ping-pong controller between a hysteresis producer and a Hough consumer sharing two
//   external frame buffers. Each bank cycles EMPTY -> FILL -> READY -> DRAIN -> EMPTY.
//   Writes go to bank[wr_sel], Hough reads come from bank[rd_sel].
//   Ports:
//     clock : rising-edge clock
//     reset : asynchronous, active-high
//     bus   : hyst_pingpong_ctrl_if.slave (producer, consumer, BRAM and status signals)
module hyst_pingpong_ctrl #(
    parameter int unsigned REDUCED_IMAGE_SIZE = 233910
) (
    input logic                 clock,
    input logic                 reset,
    hyst_pingpong_ctrl_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(REDUCED_IMAGE_SIZE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REDUCED_IMAGE_SIZE - 1);

    typedef enum logic [1:0] {BankEmpty, BankFill, BankReady, BankDrain} bank_state_e;
    typedef enum logic [1:0] {RdIdle, RdStart, RdBusy} rd_state_e;

    bank_state_e bank_q [2];
    bank_state_e bank_d [2];
    logic        wr_sel_q, wr_sel_d;
    logic        rd_sel_q, rd_sel_d;
    rd_state_e   rd_q, rd_d;
    logic        start_q, start_d;
    logic        valid_q, valid_d;
    // Bank that the outstanding read was issued to; rd_sel may toggle before data returns.
    logic        data_sel_q, data_sel_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        overflow_q, overflow_d;
    logic        protocol_q, protocol_d;

    logic        wr_ready;
    logic        addr_ok;
    logic        wr_fire;
    logic        busy;

    always_comb begin
        wr_ready = (bank_q[wr_sel_q] == BankEmpty) || (bank_q[wr_sel_q] == BankFill);
        addr_ok  = bus.hyst_wr_addr <= LAST_ADDR;
        wr_fire  = bus.hyst_wr_en && wr_ready && addr_ok;
        busy     = rd_q == RdBusy;
    end

    // Write path is a pure pass-through; only the strobe is steered and qualified.
    assign bus.wr_ready      = wr_ready;
    assign bus.bank0_wr_en   = wr_fire && !wr_sel_q;
    assign bus.bank1_wr_en   = wr_fire && wr_sel_q;
    assign bus.bank0_wr_addr = bus.hyst_wr_addr;
    assign bus.bank1_wr_addr = bus.hyst_wr_addr;
    assign bus.bank0_wr_data = bus.hyst_wr_data;
    assign bus.bank1_wr_data = bus.hyst_wr_data;

    assign bus.bank0_rd_addr = (busy && !rd_sel_q) ? bus.hough_rd_addr : '0;
    assign bus.bank1_rd_addr = (busy && rd_sel_q) ? bus.hough_rd_addr : '0;

    assign bus.hough_start    = start_q;
    assign bus.hough_rd_valid = valid_q;
    assign bus.hough_rd_data  = !valid_q  ? 8'h00 :
                                data_sel_q ? bus.bank1_rd_data : bus.bank0_rd_data;
    assign bus.frame_count    = frame_count_q;
    assign bus.overflow_err   = overflow_q;
    assign bus.protocol_err   = protocol_q;

    always_comb begin
        bank_d[0]     = bank_q[0];
        bank_d[1]     = bank_q[1];
        wr_sel_d      = wr_sel_q;
        rd_sel_d      = rd_sel_q;
        rd_d          = rd_q;
        start_d       = 1'b0;
        valid_d       = 1'b0;
        data_sel_d    = rd_sel_q;
        frame_count_d = frame_count_q;
        overflow_d    = overflow_q;
        protocol_d    = protocol_q;

        // Producer side: touches only bank[wr_sel], which is never in READY/DRAIN when
        // it changes here, so it cannot collide with the consumer-side updates below.
        if (wr_fire && (bank_q[wr_sel_q] == BankEmpty)) begin
            bank_d[wr_sel_q] = BankFill;
        end
        if (bus.hyst_wr_en && !wr_ready) begin
            overflow_d = 1'b1;
        end
        if (bus.hyst_wr_en && !addr_ok) begin
            protocol_d = 1'b1;
        end
        if (bus.hyst_done) begin
            if (bank_q[wr_sel_q] == BankFill) begin
                bank_d[wr_sel_q] = BankReady;
                wr_sel_d         = !wr_sel_q;
            end else begin
                protocol_d = 1'b1;
            end
        end

        // Consumer side.
        case (rd_q)
            RdIdle: begin
                if (bank_q[rd_sel_q] == BankReady) begin
                    bank_d[rd_sel_q] = BankDrain;
                    rd_d             = RdStart;
                    start_d          = 1'b1;
                end
            end
            RdStart: begin
                rd_d = RdBusy;
            end
            RdBusy: begin
                valid_d = bus.hough_rd_en;
                if (bus.hough_done) begin
                    bank_d[rd_sel_q] = BankEmpty;
                    rd_sel_d         = !rd_sel_q;
                    frame_count_d    = frame_count_q + 16'd1;
                    rd_d             = RdIdle;
                end
            end
            default: begin
                rd_d = RdIdle;
            end
        endcase

        if (!busy && (bus.hough_rd_en || bus.hough_done)) begin
            protocol_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bank_q[0]     <= BankEmpty;
            bank_q[1]     <= BankEmpty;
            wr_sel_q      <= 1'b0;
            rd_sel_q      <= 1'b0;
            rd_q          <= RdIdle;
            start_q       <= 1'b0;
            valid_q       <= 1'b0;
            data_sel_q    <= 1'b0;
            frame_count_q <= 16'd0;
            overflow_q    <= 1'b0;
            protocol_q    <= 1'b0;
        end else begin
            bank_q[0]     <= bank_d[0];
            bank_q[1]     <= bank_d[1];
            wr_sel_q      <= wr_sel_d;
            rd_sel_q      <= rd_sel_d;
            rd_q          <= rd_d;
            start_q       <= start_d;
            valid_q       <= valid_d;
            data_sel_q    <= data_sel_d;
            frame_count_q <= frame_count_d;
            overflow_q    <= overflow_d;
            protocol_q    <= protocol_d;
        end
    end
endmodule

// File: doc/hyst_pingpong_ctrl.md
HYST_PINGPONG_CTRL -- requirements
Module: hyst_pingpong_ctrl

Interface
REQ-001 SHALL have parameter REDUCED_IMAGE_SIZE, default 233910, meaning words per frame in the reduced-image buffer.
REQ-002 SHALL derive localparam ADDR_W = $clog2(REDUCED_IMAGE_SIZE), which is 18 at the default.
REQ-003 SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-005 SHALL have port hyst_wr_en, input, 1 bit: hysteresis write strobe.
REQ-006 SHALL have port hyst_wr_addr, input, ADDR_W bits: hysteresis write address.
REQ-007 SHALL have port hyst_wr_data, input, 8 bits: hysteresis write data.
REQ-008 SHALL have port hyst_done, input, 1 bit: one-cycle pulse marking the end of a hysteresis frame.
REQ-009 SHALL have port wr_ready, output, 1 bit: the current write bank accepts writes.
REQ-010 SHALL have port hough_start, output, 1 bit: one-cycle pulse to start Hough on a full bank.
REQ-011 SHALL have port hough_rd_en, input, 1 bit: Hough read strobe.
REQ-012 SHALL have port hough_rd_addr, input, ADDR_W bits: Hough read address.
REQ-013 SHALL have port hough_rd_data, output, 8 bits: read data.
REQ-014 SHALL have port hough_rd_valid, output, 1 bit: qualifies hough_rd_data.
REQ-015 SHALL have port hough_done, input, 1 bit: one-cycle pulse marking the end of Hough consumption.
REQ-016 SHALL have ports bankN_wr_en (1 bit), bankN_wr_addr (ADDR_W), bankN_wr_data (8), bankN_rd_addr (ADDR_W) as outputs, and bankN_rd_data (8) as input, for N = 0 and 1; external BRAM read latency is 1 cycle.
REQ-017 SHALL have port frame_count, output, 16 bits: number of frames fully consumed by Hough.
REQ-018 SHALL have port overflow_err, output, 1 bit: sticky flag for a dropped write.
REQ-019 SHALL have port protocol_err, output, 1 bit: sticky flag for a misplaced pulse or read.

Function
REQ-020 SHALL keep a 2-bit state per bank: EMPTY, FILL, READY, DRAIN.
REQ-021 SHALL keep pointers wr_sel and rd_sel, each 1 bit, selecting the write bank and the read bank.
REQ-022 SHALL drive wr_ready = 1 when bank[wr_sel] is EMPTY or FILL, and 0 otherwise (combinational).
REQ-023 On hyst_wr_en with wr_ready=1 and hyst_wr_addr < REDUCED_IMAGE_SIZE, SHALL assert bank[wr_sel]_wr_en in the same cycle, passing address and data through combinationally.
REQ-024 On such a write, SHALL move bank[wr_sel] from EMPTY to FILL on the next clock.
REQ-025 On hyst_wr_en with wr_ready=0, SHALL drop the write, keep both bank wr_en at 0, and set overflow_err.
REQ-026 On hyst_wr_en with an address >= REDUCED_IMAGE_SIZE, SHALL drop the write and set protocol_err.
REQ-027 On hyst_done while bank[wr_sel]=FILL, SHALL move that bank to READY and toggle wr_sel on the next clock.
REQ-028 On hyst_done while bank[wr_sel] is not FILL, SHALL ignore the pulse and set protocol_err.
REQ-029 SHALL use a read FSM with states IDLE, START, BUSY; the reset state is IDLE.
REQ-030 In IDLE, when bank[rd_sel]=READY, SHALL move that bank to DRAIN and the FSM to START.
REQ-031 In START, SHALL assert hough_start for exactly 1 cycle, then go to BUSY.
REQ-032 In BUSY, SHALL drive bank[rd_sel]_rd_addr = hough_rd_addr.
REQ-033 In BUSY, hough_rd_valid SHALL equal hough_rd_en delayed by 1 cycle.
REQ-034 When hough_rd_valid=1, hough_rd_data SHALL be bank[rd_sel]_rd_data; otherwise hough_rd_data SHALL be 0.
REQ-035 On hough_rd_en outside BUSY, SHALL set protocol_err, with no valid response.
REQ-036 On hough_done in BUSY, SHALL move bank[rd_sel] to EMPTY, toggle rd_sel, increment frame_count (wrapping 0xFFFF -> 0), and return to IDLE.
REQ-037 On hough_done outside BUSY, SHALL ignore the pulse and set protocol_err.
REQ-038 SHALL apply hyst_done and hough_done in the same cycle together; they target different banks by construction.
REQ-039 SHALL allow a bank freed by hough_done to accept a write on the following cycle, giving a 1-cycle latency from free to wr_ready.
REQ-040 SHALL guarantee that at most one bank wr_en is high in any cycle, and that the bank in DRAIN never receives wr_en.
REQ-041 SHALL clear overflow_err and protocol_err only by reset.

Reset
REQ-042 On reset, SHALL set both banks to EMPTY, wr_sel=0, rd_sel=0, and the FSM to IDLE.
REQ-043 On reset, SHALL set hough_start=0, hough_rd_valid=0, hough_rd_data=0, frame_count=0, overflow_err=0, protocol_err=0, and all bank wr_en=0.
REQ-044 On reset, wr_ready SHALL be 1.
REQ-045 Reset asserted mid-frame SHALL discard both banks' contents logically; no hough_start pulse follows until a new frame completes.

Verification
REQ-046 Single frame: write addrs 0..9 with data = addr, then pulse hyst_done -> bank0 receives 10 writes; hough_start pulses 2 cycles after hyst_done; reads of addrs 0..9 return 0..9 with valid 1 cycle later; hough_done -> frame_count=1.
REQ-047 Ping-pong: while Hough is BUSY on bank0, write frame 2 -> all writes land on bank1 and wr_ready stays 1; the second hough_start fires 2 cycles after the first hough_done.
REQ-048 Overflow: both banks READY/DRAIN and one more hyst_wr_en -> no bank wr_en asserted, overflow_err=1, wr_ready=0.
REQ-049 Protocol: hough_done in IDLE, hyst_done with no prior write, and write to addr 233910 -> each sets protocol_err; bank states are unchanged.
REQ-050 Simultaneous: hyst_done (bank1) and hough_done (bank0) in the same cycle -> next cycle bank0=EMPTY, bank1=READY, wr_sel=0, rd_sel=1; hough_start follows.
REQ-051 Reset mid-BUSY: assert reset -> all outputs return to reset values immediately, and no hough_rd_valid is seen afterwards.
